// File: rtl/instr_register_pipe.sv
// -----------------------------------------------------------------------------
// instr_register_pipe
//
// Instruction register with a 2-stage arithmetic pipeline.
// Each instruction carries an opcode and two signed operands.
// The instruction, its signed result and an error flag are stored into a
// DEPTH-entry array. A registered read port returns the stored contents.
// A sequenced clear engine first drains the pipeline and then zeroes one
// entry per cycle.
//
// Parameters
//   OPW   operand width (signed), result is 2*OPW
//   DEPTH number of entries (power of 2)
//   AW    pointer width, derived from DEPTH
//
// Optional feature (compile-time macro IR_PARITY_EN)
//   Stores an even-parity bit per entry and adds the rd_perr output.
//
// Ports
//   clk, reset_n              clock (rising edge), async active-low reset
//   wr_valid / wr_ready       write handshake (wr_ready low while clearing)
//   wr_opcode, wr_op_a/b      instruction to execute
//   wr_ptr                    destination entry
//   rd_en, rd_ptr             read request, sampled on the clock edge
//   rd_valid                  one-cycle pulse after a read request
//   rd_opcode/op_a/op_b       stored instruction
//   rd_result/err/written     stored result, error flag, written flag
//   rd_perr                   parity mismatch on the read entry (IR_PARITY_EN)
//   clr                       clear request pulse
//   clr_busy, clr_done        clear in progress / one-cycle completion pulse
//   busy                      a pipeline stage holds a valid instruction
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module instr_register_pipe #(
    parameter  int OPW   = 32,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [3:0]             wr_opcode,
    input  logic signed [OPW-1:0]  wr_op_a,
    input  logic signed [OPW-1:0]  wr_op_b,
    input  logic [AW-1:0]          wr_ptr,
    input  logic                   rd_en,
    input  logic [AW-1:0]          rd_ptr,
    output logic                   rd_valid,
    output logic [3:0]             rd_opcode,
    output logic signed [OPW-1:0]  rd_op_a,
    output logic signed [OPW-1:0]  rd_op_b,
    output logic signed [2*OPW-1:0] rd_result,
    output logic                   rd_err,
    output logic                   rd_written,
`ifdef IR_PARITY_EN
    output logic                   rd_perr,
`endif
    input  logic                   clr,
    output logic                   clr_busy,
    output logic                   clr_done,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_e;

    // Returns {err, result}. Operands are sign-extended to 2*OPW before the
    // operation, so the full product and the -min/-1 quotient both fit.
    function automatic logic [2*OPW:0] alu(
        input logic [3:0]            opc,
        input logic signed [OPW-1:0] a,
        input logic signed [OPW-1:0] b
    );
        logic signed [2*OPW-1:0] ax;
        logic signed [2*OPW-1:0] bx;
        logic signed [2*OPW-1:0] bdiv;
        logic signed [2*OPW-1:0] res;
        logic                    err;
        logic                    bzero;
        ax    = {{OPW{a[OPW-1]}}, a};
        bx    = {{OPW{b[OPW-1]}}, b};
        bzero = (b == '0);
        // Divisor forced to 1 when b is zero so the divider never sees 0.
        bdiv  = bzero ? {{(2*OPW-1){1'b0}}, 1'b1} : bx;
        res   = '0;
        err   = 1'b0;
        case (opc)
            4'd0: res = '0;
            4'd1: res = ax;
            4'd2: res = bx;
            4'd3: res = ax + bx;
            4'd4: res = ax - bx;
            4'd5: res = ax * bx;
            4'd6: begin
                if (bzero) err = 1'b1;
                else       res = ax / bdiv;
            end
            4'd7: begin
                if (bzero) err = 1'b1;
                else       res = ax % bdiv;
            end
            default: err = 1'b1;
        endcase
        return {err, res};
    endfunction

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            clr_done_q, clr_done_d;
    logic            wr_fire;

    logic                    vld_p1_q;
    logic [3:0]              opc_p1_q;
    logic signed [OPW-1:0]   a_p1_q;
    logic signed [OPW-1:0]   b_p1_q;
    logic [AW-1:0]           ptr_p1_q;

    logic signed [2*OPW-1:0] alu_res;
    logic                    alu_err;

    logic                    vld_p2_q;
    logic [3:0]              opc_p2_q;
    logic signed [OPW-1:0]   a_p2_q;
    logic signed [OPW-1:0]   b_p2_q;
    logic [AW-1:0]           ptr_p2_q;
    logic signed [2*OPW-1:0] res_p2_q;
    logic                    err_p2_q;

    logic [3:0]              mem_opc_q [DEPTH];
    logic signed [OPW-1:0]   mem_a_q   [DEPTH];
    logic signed [OPW-1:0]   mem_b_q   [DEPTH];
    logic signed [2*OPW-1:0] mem_res_q [DEPTH];
    logic                    mem_err_q [DEPTH];
    logic                    mem_wr_q  [DEPTH];

    logic                    rd_valid_q;
    logic [3:0]              rd_opc_q;
    logic signed [OPW-1:0]   rd_a_q;
    logic signed [OPW-1:0]   rd_b_q;
    logic signed [2*OPW-1:0] rd_res_q;
    logic                    rd_err_q;
    logic                    rd_wr_q;

`ifdef IR_PARITY_EN
    logic                    par_p2_q;
    logic                    mem_par_q [DEPTH];
    logic                    rd_perr_q;
`endif

    assign wr_ready = (state_q == IDLE);
    assign wr_fire  = wr_valid && wr_ready;
    assign busy     = vld_p1_q | vld_p2_q;
    assign clr_busy = (state_q != IDLE);
    assign clr_done = clr_done_q;

    // ---- Stage 1: capture accepted instruction ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= wr_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            opc_p1_q <= wr_opcode;
            a_p1_q   <= wr_op_a;
            b_p1_q   <= wr_op_b;
            ptr_p1_q <= wr_ptr;
        end
    end

    always_comb begin
        {alu_err, alu_res} = alu(opc_p1_q, a_p1_q, b_p1_q);
    end

    // ---- Stage 2: register result and error ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2_q <= 1'b0;
        end else begin
            vld_p2_q <= vld_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1_q) begin
            opc_p2_q <= opc_p1_q;
            a_p2_q   <= a_p1_q;
            b_p2_q   <= b_p1_q;
            ptr_p2_q <= ptr_p1_q;
            res_p2_q <= alu_res;
            err_p2_q <= alu_err;
`ifdef IR_PARITY_EN
            par_p2_q <= ^{opc_p1_q, a_p1_q, b_p1_q, alu_res, alu_err};
`endif
        end
    end

    // ---- Array write: pipeline commit and clear engine ----
    // The clear engine only runs with an empty pipeline, so the two write
    // sources never target the array in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_opc_q[i] <= '0;
                mem_a_q[i]   <= '0;
                mem_b_q[i]   <= '0;
                mem_res_q[i] <= '0;
                mem_err_q[i] <= 1'b0;
                mem_wr_q[i]  <= 1'b0;
`ifdef IR_PARITY_EN
                mem_par_q[i] <= 1'b0;
`endif
            end
        end else begin
            if (vld_p2_q) begin
                mem_opc_q[ptr_p2_q] <= opc_p2_q;
                mem_a_q[ptr_p2_q]   <= a_p2_q;
                mem_b_q[ptr_p2_q]   <= b_p2_q;
                mem_res_q[ptr_p2_q] <= res_p2_q;
                mem_err_q[ptr_p2_q] <= err_p2_q;
                mem_wr_q[ptr_p2_q]  <= 1'b1;
`ifdef IR_PARITY_EN
                mem_par_q[ptr_p2_q] <= par_p2_q;
`endif
            end
            if (state_q == CLEAR) begin
                mem_opc_q[clr_cnt_q] <= '0;
                mem_a_q[clr_cnt_q]   <= '0;
                mem_b_q[clr_cnt_q]   <= '0;
                mem_res_q[clr_cnt_q] <= '0;
                mem_err_q[clr_cnt_q] <= 1'b0;
                mem_wr_q[clr_cnt_q]  <= 1'b0;
`ifdef IR_PARITY_EN
                mem_par_q[clr_cnt_q] <= 1'b0;
`endif
            end
        end
    end

    // ---- Read port: registered, no bypass of a same-edge array write ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_opc_q   <= '0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            rd_res_q   <= '0;
            rd_err_q   <= 1'b0;
            rd_wr_q    <= 1'b0;
`ifdef IR_PARITY_EN
            rd_perr_q  <= 1'b0;
`endif
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_opc_q <= mem_opc_q[rd_ptr];
                rd_a_q   <= mem_a_q[rd_ptr];
                rd_b_q   <= mem_b_q[rd_ptr];
                rd_res_q <= mem_res_q[rd_ptr];
                rd_err_q <= mem_err_q[rd_ptr];
                rd_wr_q  <= mem_wr_q[rd_ptr];
`ifdef IR_PARITY_EN
                rd_perr_q <= (^{mem_opc_q[rd_ptr], mem_a_q[rd_ptr], mem_b_q[rd_ptr],
                                mem_res_q[rd_ptr], mem_err_q[rd_ptr]}) ^ mem_par_q[rd_ptr];
`endif
            end
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_opcode  = rd_opc_q;
    assign rd_op_a    = rd_a_q;
    assign rd_op_b    = rd_b_q;
    assign rd_result  = rd_res_q;
    assign rd_err     = rd_err_q;
    assign rd_written = rd_wr_q;
`ifdef IR_PARITY_EN
    assign rd_perr    = rd_perr_q;
`endif

    // ---- Clear FSM ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_done_q <= clr_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                clr_cnt_d = '0;
                // A write accepted on the same edge as clr is still in
                // flight, so it must drain before clearing starts.
                if (clr) state_d = (busy || wr_fire) ? DRAIN : CLEAR;
            end
            DRAIN: begin
                if (!busy) state_d = CLEAR;
            end
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_register_pipe.sv
`timescale 1ns/1ps

module tb_instr_register_pipe;

    localparam int OPW   = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NV    = 14;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [3:0]            wr_opcode;
    logic [OPW-1:0]        wr_op_a;
    logic [OPW-1:0]        wr_op_b;
    logic [AW-1:0]         wr_ptr;
    logic                  rd_en;
    logic [AW-1:0]         rd_ptr;
    logic                  rd_valid;
    logic [3:0]            rd_opcode;
    logic [OPW-1:0]        rd_op_a;
    logic [OPW-1:0]        rd_op_b;
    logic [2*OPW-1:0]      rd_result;
    logic                  rd_err;
    logic                  rd_written;
`ifdef IR_PARITY_EN
    logic                  rd_perr;
`endif
    logic                  clr;
    logic                  clr_busy;
    logic                  clr_done;
    logic                  busy;

    always #5 clk = ~clk;

    instr_register_pipe #(.OPW(OPW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_opcode  (wr_opcode),
        .wr_op_a    (wr_op_a),
        .wr_op_b    (wr_op_b),
        .wr_ptr     (wr_ptr),
        .rd_en      (rd_en),
        .rd_ptr     (rd_ptr),
        .rd_valid   (rd_valid),
        .rd_opcode  (rd_opcode),
        .rd_op_a    (rd_op_a),
        .rd_op_b    (rd_op_b),
        .rd_result  (rd_result),
        .rd_err     (rd_err),
        .rd_written (rd_written),
`ifdef IR_PARITY_EN
        .rd_perr    (rd_perr),
`endif
        .clr        (clr),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .busy       (busy)
    );

    typedef struct {
        logic [3:0]       opc;
        logic [OPW-1:0]   a;
        logic [OPW-1:0]   b;
        logic [AW-1:0]    ptr;
        logic [2*OPW-1:0] res;
        logic             err;
    } vec_t;

    vec_t vecs [NV];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue a one-cycle read; returns at the negedge after the sampling edge.
    task automatic do_read(input logic [AW-1:0] p);
        rd_en  = 1'b1;
        rd_ptr = p;
        @(negedge clk);
        rd_en  = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] opc, input logic [OPW-1:0] a,
                            input logic [OPW-1:0] b, input logic [AW-1:0] p);
        wr_valid  = 1'b1;
        wr_opcode = opc;
        wr_op_a   = a;
        wr_op_b   = b;
        wr_ptr    = p;
        @(negedge clk);
        wr_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbusy;
        int ndone;
        int guard;
        int wr_bad;

        wr_valid = 1'b0; wr_opcode = '0; wr_op_a = '0; wr_op_b = '0; wr_ptr = '0;
        rd_en = 1'b0; rd_ptr = '0; clr = 1'b0;
        reset_n = 1'b0;

        vecs[0]  = '{4'd3, 32'hFFFF_FFFB, 32'd7,        5'd3,  64'd2,                   1'b0};
        vecs[1]  = '{4'd5, 32'h7FFF_FFFF, 32'd2,        5'd4,  64'h0000_0000_FFFF_FFFE, 1'b0};
        vecs[2]  = '{4'd6, 32'hFFFF_FFF9, 32'd2,        5'd6,  64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
        vecs[3]  = '{4'd7, 32'hFFFF_FFF9, 32'd2,        5'd7,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[4]  = '{4'd6, 32'd9,         32'd0,        5'd8,  64'd0,                   1'b1};
        vecs[5]  = '{4'd12, 32'd1,        32'd2,        5'd9,  64'd0,                   1'b1};
        vecs[6]  = '{4'd0, 32'd5,         32'd6,        5'd10, 64'd0,                   1'b0};
        vecs[7]  = '{4'd1, 32'hFFFF_FFF7, 32'd4,        5'd11, 64'hFFFF_FFFF_FFFF_FFF7, 1'b0};
        vecs[8]  = '{4'd2, 32'd3,         32'hFFFF_FFFE, 5'd12, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[9]  = '{4'd4, 32'd10,        32'd3,        5'd13, 64'd7,                   1'b0};
        vecs[10] = '{4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 64'h0000_0000_8000_0000, 1'b0};
        vecs[11] = '{4'd5, 32'h8000_0000, 32'h8000_0000, 5'd15, 64'h4000_0000_0000_0000, 1'b0};
        vecs[12] = '{4'd7, 32'd7,         32'hFFFF_FFFE, 5'd16, 64'd1,                   1'b0};
        vecs[13] = '{4'd7, 32'd5,         32'd0,        5'd17, 64'd0,                   1'b1};

        repeat (2) @(negedge clk);

        // Reset state
        check("rst_wr_ready", 64'(wr_ready), 64'd1);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_clr_busy", 64'(clr_busy), 64'd0);
        check("rst_clr_done", 64'(clr_done), 64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_rd_result", rd_result,    64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Every entry reads back zero after reset
        for (int i = 0; i < DEPTH; i++) begin
            do_read(AW'(i));
            check("t1_rd_valid", 64'(rd_valid), 64'd1);
            check("t1_result",   rd_result, 64'd0);
            check("t1_written",  64'(rd_written), 64'd0);
            check("t1_fields",   64'(|{rd_opcode, rd_op_a, rd_op_b, rd_err}), 64'd0);
        end
        @(negedge clk);
        check("t1_rd_valid_drop", 64'(rd_valid), 64'd0);

        // Arithmetic table, back-to-back writes
        for (int i = 0; i < NV; i++) begin
            check("t2_wr_ready", 64'(wr_ready), 64'd1);
            wr_valid  = 1'b1;
            wr_opcode = vecs[i].opc;
            wr_op_a   = vecs[i].a;
            wr_op_b   = vecs[i].b;
            wr_ptr    = vecs[i].ptr;
            @(negedge clk);
            check("t2_busy", 64'(busy), 64'd1);
        end
        wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t2_busy_idle", 64'(busy), 64'd0);
        for (int i = 0; i < NV; i++) begin
            do_read(vecs[i].ptr);
            check("t2_rd_valid", 64'(rd_valid),   64'd1);
            check("t2_result",   rd_result,       vecs[i].res);
            check("t2_err",      64'(rd_err),     64'(vecs[i].err));
            check("t2_opcode",   64'(rd_opcode),  64'(vecs[i].opc));
            check("t2_op_a",     64'(rd_op_a),    64'(vecs[i].a));
            check("t2_op_b",     64'(rd_op_b),    64'(vecs[i].b));
            check("t2_written",  64'(rd_written), 64'd1);
        end

        // Read at the array-write edge returns old data; one edge later new data
        do_write(4'd4, 32'd10, 32'd3, 5'd5);
        @(negedge clk);
        rd_en = 1'b1; rd_ptr = 5'd5;
        @(negedge clk);
        check("t4_old_written", 64'(rd_written), 64'd0);
        check("t4_old_result",  rd_result,       64'd0);
        @(negedge clk);
        rd_en = 1'b0;
        check("t4_new_valid",   64'(rd_valid),   64'd1);
        check("t4_new_result",  rd_result,       64'd7);
        check("t4_new_written", 64'(rd_written), 64'd1);

        // Clear after three back-to-back writes, second clr ignored
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1'b1; wr_opcode = 4'd3; wr_op_a = OPW'(k); wr_op_b = 32'd1;
            wr_ptr = AW'(20 + k);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t5_wr_ready_low", 64'(wr_ready), 64'd0);
        check("t5_clr_busy",     64'(clr_busy), 64'd1);
        nbusy = 1; ndone = 0; guard = 0; wr_bad = 0;
        while (clr_busy === 1'b1 && guard < 200) begin
            if (wr_ready !== 1'b0) wr_bad++;
            if (nbusy == 10) clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            guard++;
            if (clr_done === 1'b1) ndone++;
            if (clr_busy === 1'b1) nbusy++;
        end
        check("t5_timeout",     64'(guard < 200), 64'd1);
        check("t5_busy_cycles", 64'(nbusy), 64'(DEPTH + 2));
        check("t5_wr_ready_busy", 64'(wr_bad), 64'd0);
        repeat (3) begin
            @(negedge clk);
            if (clr_done === 1'b1) ndone++;
            if (clr_busy === 1'b1) nbusy++;
        end
        check("t5_done_pulses", 64'(ndone), 64'd1);
        check("t5_no_restart",  64'(nbusy), 64'(DEPTH + 2));
        for (int i = 0; i < DEPTH; i++) begin
            do_read(AW'(i));
            check("t5_cleared_result",  rd_result,       64'd0);
            check("t5_cleared_written", 64'(rd_written), 64'd0);
        end

        // Reset in the middle of a clear
        do_write(4'd1, 32'd42, 32'd0, 5'd27);
        repeat (3) @(negedge clk);
        do_read(5'd27);
        check("t6_pre_result", rd_result, 64'd42);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t6_clearing", 64'(clr_busy), 64'd1);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t6_rst_clr_busy",  64'(clr_busy),   64'd0);
        check("t6_rst_wr_ready",  64'(wr_ready),   64'd1);
        check("t6_rst_rd_result", rd_result,       64'd0);
        check("t6_rst_rd_opcode", 64'(rd_opcode),  64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        nbusy = 0; ndone = 0;
        repeat (DEPTH + 4) begin
            @(negedge clk);
            if (clr_busy === 1'b1) nbusy++;
            if (clr_done === 1'b1) ndone++;
        end
        check("t6_idle_after", 64'(nbusy), 64'd0);
        check("t6_no_done",    64'(ndone), 64'd0);

        // Reset with writes in flight
        wr_valid = 1'b1; wr_opcode = 4'd3; wr_op_a = 32'd1; wr_op_b = 32'd1; wr_ptr = 5'd25;
        @(negedge clk);
        wr_ptr = 5'd26;
        @(negedge clk);
        wr_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        do_read(5'd25);
        check("t6_lost_25", 64'(rd_written), 64'd0);
        do_read(5'd26);
        check("t6_lost_26", 64'(rd_written), 64'd0);
        do_read(5'd27);
        check("t6_zeroed_27", 64'(rd_written), 64'd0);
        check("t6_zeroed_27_res", rd_result, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
